// File: rtl/regfile_pkg.sv
// Shared defaults for the register-file scoreboard and the address-width helper.
// Contents: default DATA_W / NUM_REGS / NRD / NWR values and addr_w_f(),
// a ceil(log2(n)) used to derive the (non-overridable) ADDR_W everywhere.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned NRD_DEF      = 2;
    localparam int unsigned NWR_DEF      = 2;

    // ceil(log2(n)); n is a power of two for NUM_REGS so this is exact
    function automatic int unsigned addr_w_f(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(n)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle between the issue/execute pipeline and the register-file scoreboard.
// master: drives rd_addr, wr_en/wr_addr/wr_data, alloc_en/alloc_addr;
//         receives rd_data, rd_busy (combinational), busy_vec, err_unalloc (registered).
// slave:  the scoreboard side, directions reversed.
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NRD      = NRD_DEF,
    parameter int unsigned NWR      = NWR_DEF
);
    localparam int unsigned ADDR_W = addr_w_f(NUM_REGS);

    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*ADDR_W-1:0] wr_addr;
    logic [NWR*DATA_W-1:0] wr_data;
    logic                  alloc_en;
    logic [ADDR_W-1:0]     alloc_addr;
    logic [NUM_REGS-1:0]   busy_vec;
    logic                  err_unalloc;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy, busy_vec, err_unalloc
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy, busy_vec, err_unalloc
    );

endinterface

// File: rtl/rf_write_resolve.sv
// Finds which write port (if any) targets match_addr_i; highest-index port wins.
// Ports: match_addr_i  address to test
//        wr_en_i/wr_addr_i/wr_data_i  packed write ports
//        hit_o   combinational: some enabled port targets match_addr_i
//        data_o  combinational: data of the winning port (0 when no hit)
module rf_write_resolve #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NWR    = 2
) (
    input  logic [ADDR_W-1:0]     match_addr_i,
    input  logic [NWR-1:0]        wr_en_i,
    input  logic [NWR*ADDR_W-1:0] wr_addr_i,
    input  logic [NWR*DATA_W-1:0] wr_data_i,
    output logic                  hit_o,
    output logic [DATA_W-1:0]     data_o
);

    // ascending scan: later (higher-index) matches overwrite earlier ones
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int unsigned j = 0; j < NWR; j++) begin
            if (wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == match_addr_i)) begin
                hit_o  = 1'b1;
                data_o = wr_data_i[j*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-ported flop register file with a pending-producer scoreboard.
// Ports: clk  rising-edge clock
//        rst  asynchronous active-low reset
//        bus  slave side of regfile_scoreboard_if:
//             rd_addr -> rd_data / rd_busy (zero latency, same-cycle write bypass)
//             wr_*     commit at the edge, clear the busy bit
//             alloc_*  set the busy bit at the edge
//             busy_vec registered pending bits, err_unalloc sticky write-without-alloc flag
// Register 0 is hardwired to zero and never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NRD      = NRD_DEF,
    parameter int unsigned NWR      = NWR_DEF
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);

    localparam int unsigned ADDR_W = addr_w_f(NUM_REGS);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic                err_q;
    logic                err_d;

    logic [NUM_REGS-1:1] wr_hit;
    logic [DATA_W-1:0]   wr_val [1:NUM_REGS-1];
    logic [NUM_REGS-1:1] err_set;

    // per-register next state; register 0 stays constant zero
    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r == 0) begin : g_zero
            assign regs_d[0] = '0;
            assign busy_d[0] = 1'b0;
        end else begin : g_arch
            logic alloc_hit;

            rf_write_resolve #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .NWR    (NWR)
            ) u_wr_resolve (
                .match_addr_i (ADDR_W'(r)),
                .wr_en_i      (bus.wr_en),
                .wr_addr_i    (bus.wr_addr),
                .wr_data_i    (bus.wr_data),
                .hit_o        (wr_hit[r]),
                .data_o       (wr_val[r])
            );

            assign alloc_hit  = bus.alloc_en && (bus.alloc_addr == ADDR_W'(r));
            assign regs_d[r]  = wr_hit[r] ? wr_val[r] : regs_q[r];
            // a same-cycle alloc is a newer producer than the retiring write
            assign busy_d[r]  = alloc_hit || (busy_q[r] && !wr_hit[r]);
            // judged on the pre-edge busy bit, so a racing alloc does not mask it
            assign err_set[r] = wr_hit[r] && !busy_q[r];
        end
    end

    assign err_d = err_q || (|err_set);

    // state: storage, pending bits, sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    logic [NRD*DATA_W-1:0] rd_data_c;
    logic [NRD-1:0]        rd_busy_c;

    // read ports: bypass from same-cycle writes, forced to zero in reset
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_a;
        logic              rd_hit;
        logic [DATA_W-1:0] rd_byp;
        logic              rd_live;

        assign rd_a    = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign rd_live = rst && (rd_a != '0);

        rf_write_resolve #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NWR    (NWR)
        ) u_rd_resolve (
            .match_addr_i (rd_a),
            .wr_en_i      (bus.wr_en),
            .wr_addr_i    (bus.wr_addr),
            .wr_data_i    (bus.wr_data),
            .hit_o        (rd_hit),
            .data_o       (rd_byp)
        );

        assign rd_data_c[k*DATA_W +: DATA_W] = !rd_live ? '0 :
                                               (rd_hit ? rd_byp : regs_q[rd_a]);
        assign rd_busy_c[k] = rd_live && busy_q[rd_a] && !rd_hit;
    end

    assign bus.rd_data     = rd_data_c;
    assign bus.rd_busy     = rd_busy_c;
    assign bus.busy_vec    = busy_q;
    assign bus.err_unalloc = err_q;

endmodule
